// File: rtl/upuart_rx_if.sv
// Receive-side byte handshake between upuart_rx and its consumer
// (register/FIFO logic). The receiver drives the byte, its framing flag and
// valid. The consumer drives ready.
interface upuart_rx_if;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_ferr, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_ferr, input rx_valid, output rx_ready);
endinterface

// File: rtl/upuart_rx.sv
// upuart_rx: 8N1 UART receive deserializer using a 16x oversampling strobe.
// Each bit is sampled three times (ticks 7, 8 and 9 of the bit) and the
// samples are voted 2-of-3. The frame ends at mid-stop so the receiver can
// resync on a start edge that follows immediately. Completed bytes land in a
// valid/ready output register. A completion that finds the register still
// full is dropped and reported with a one-cycle overrun pulse.
module upuart_rx (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        tick,
  input  logic        rxd,
  upuart_rx_if.master rx,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 2-of-3 majority vote over the three mid-bit samples
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  state_t      state_r, state_n;
  logic [1:0]  sync_r;
  logic        rxs_s;
  logic [3:0]  tcnt_r, tcnt_n;
  logic [2:0]  bcnt_r, bcnt_n;
  logic [7:0]  shift_r, shift_n;
  logic [2:0]  samp_r, samp_n;
  logic        maj_now_s;
  logic        maj_all_s;
  logic        done_s;
  logic        ferr_s;
  logic [7:0]  data_r;
  logic        ferr_r;
  logic        valid_r;
  logic        overrun_r;

  assign rxs_s = sync_r[1];
  // Vote that includes the sample being taken on this tick (tcnt 9 decisions)
  assign maj_now_s = maj3({samp_r[1:0], rxs_s});
  // Vote over the three stored samples (end-of-bit decisions)
  assign maj_all_s = maj3(samp_r);

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  // Frame state, tick/bit counters, shift register and sample history
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= IDLE;
      tcnt_r  <= 4'd0;
      bcnt_r  <= 3'd0;
      shift_r <= 8'h00;
      samp_r  <= 3'b000;
    end else begin
      state_r <= state_n;
      tcnt_r  <= tcnt_n;
      bcnt_r  <= bcnt_n;
      shift_r <= shift_n;
      samp_r  <= samp_n;
    end
  end

  // Next-state logic: advance only on tick; disable forces IDLE with counters cleared
  always_comb begin
    state_n = state_r;
    tcnt_n  = tcnt_r;
    bcnt_n  = bcnt_r;
    shift_n = shift_r;
    samp_n  = samp_r;
    done_s  = 1'b0;
    ferr_s  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      tcnt_n  = 4'd0;
      bcnt_n  = 3'd0;
    end else if (tick) begin
      tcnt_n = tcnt_r + 4'd1;
      if ((tcnt_r >= 4'd7) && (tcnt_r <= 4'd9)) begin
        samp_n = {samp_r[1:0], rxs_s};
      end else begin
        samp_n = samp_r;
      end
      case (state_r)
        IDLE: begin
          // The detect tick is tick 0 of the start bit
          if (!rxs_s) begin
            state_n = START;
            tcnt_n  = 4'd1;
          end else begin
            tcnt_n  = 4'd0;
          end
        end
        START: begin
          if ((tcnt_r == 4'd9) && maj_now_s) begin
            state_n = IDLE;
            tcnt_n  = 4'd0;
          end else if (tcnt_r == 4'd15) begin
            state_n = DATA;
            bcnt_n  = 3'd0;
          end else begin
            state_n = START;
          end
        end
        DATA: begin
          if (tcnt_r == 4'd15) begin
            shift_n = {maj_all_s, shift_r[7:1]};
            bcnt_n  = bcnt_r + 3'd1;
            if (bcnt_r == 3'd7) begin
              state_n = STOP;
            end else begin
              state_n = DATA;
            end
          end else begin
            state_n = DATA;
          end
        end
        STOP: begin
          if (tcnt_r == 4'd9) begin
            done_s  = 1'b1;
            ferr_s  = ~maj_now_s;
            state_n = IDLE;
            tcnt_n  = 4'd0;
          end else begin
            state_n = STOP;
          end
        end
        default: begin
          state_n = IDLE;
          tcnt_n  = 4'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Output byte register: load on completion if free or being drained, else flag overrun
  always_ff @(posedge clk) begin
    if (!nrst) begin
      data_r    <= 8'h00;
      ferr_r    <= 1'b0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (done_s) begin
      if (!valid_r || rx.rx_ready) begin
        data_r    <= shift_r;
        ferr_r    <= ferr_s;
        valid_r   <= 1'b1;
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= 1'b1;
      end
    end else begin
      overrun_r <= 1'b0;
      if (valid_r && rx.rx_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign rx.rx_data  = data_r;
  assign rx.rx_ferr  = ferr_r;
  assign rx.rx_valid = valid_r;
  assign overrun     = overrun_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: doc/upuart_rx.md
# upuart_rx

UART receive deserializer for the upuart block: recovers 8N1 frames from the asynchronous `rxd` line using the 16x oversampling strobe produced by the baud rate generator in oversampling mode. Each received byte, with its framing-error flag, is presented on a valid/ready output register. Overrun is reported when the consumer does not drain that register in time. The block sits between the pad-side `rxd` line and the UART register/FIFO logic.

## Interface
- No parameters: 8 data bits, 1 stop bit, no parity and 16 ticks per bit are fixed.
- `clk`  in  1  system clock.
- `nrst`  in  1  reset; synchronous, active-low.
- `enable`  in  1  receiver enable; low forces IDLE.
- `tick`  in  1  single-cycle 16x-bit-rate strobe from the baud rate generator.
- `rxd`  in  1  serial input, asynchronous to `clk`, idle high.
- `rx_data`  out  8  received byte, LSB first on the line.
- `rx_ferr`  out  1  framing error for `rx_data`; qualified by `rx_valid`.
- `rx_valid`  out  1  `rx_data`/`rx_ferr` hold an unconsumed byte.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid && rx_ready`.
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1); `rxs` is the synchronized level.
- Registers:
  - 4-bit tick counter `tcnt`, which advances only on `tick` and wraps 15 -> 0.
  - 3-bit bit counter.
  - 8-bit shift register.
  - 3-sample majority register.
- States:
  - IDLE: on `tick` with `rxs`=0, go to START with `tcnt`=1 (the detect tick counts as tick 0).
  - START: samples are taken on ticks with `tcnt`=7, 8, 9.
    - On the `tcnt`=9 tick, if the majority is 1 (false start), go to IDLE.
    - On the `tcnt`=15 tick, go to DATA with `tcnt`=0 and bit counter 0.
  - DATA: samples are taken on ticks with `tcnt`=7, 8, 9.
    - On the `tcnt`=15 tick, shift the majority in at bit 7 (right shift) and increment the bit counter.
    - After the 8th bit, go to STOP.
  - STOP: samples are taken on ticks with `tcnt`=7, 8, 9.
    - On the `tcnt`=9 tick, complete the byte: `ferr` = ~majority, then go to IDLE.
    - Ending at mid-stop allows resync on a following start edge.
- Majority: at least 2 of the 3 samples at 1 gives 1.
- Byte completion, register update:
  - If `!rx_valid || rx_ready`: load `rx_data`/`rx_ferr` and set `rx_valid`=1.
  - Otherwise: pulse `overrun`, discard the new byte, and leave the held byte unchanged.
- Handshake:
  - `rx_valid && rx_ready` with no simultaneous completion clears `rx_valid` next cycle.
  - `rx_valid` is never dropped without acceptance.
- `enable`=0: state goes to IDLE and the counters clear. The output register and the handshake keep working, and the synchronizer keeps running.
- Break (line held low): frames complete with `rx_data`=0x00 and `rx_ferr`=1. IDLE re-detects a start on the next tick while `rxs`=0.
- `tick` is ignored while `enable`=0. Cycles without `tick` only hold state.

## Timing
- Reset (`nrst`=0 at a `clk` edge): state IDLE, all counters 0, synchronizer 1, `rx_data`=0x00, `rx_ferr`=0, `rx_valid`=0, `overrun`=0, `busy`=0.
- Line-to-detect latency: 2 clk synchronizer plus wait for the next `tick`.
- With the detect tick as tick 0, the stop decision falls on tick 153 (16*9+9). `rx_valid` rises 1 clk after that tick, and `overrun` pulses in that same cycle.
- `busy` rises 1 clk after the detect tick and falls 1 clk after the false-start tick or the stop-decision tick.
- Reset or `enable` deasserted mid-frame aborts it: no `rx_valid` and no `overrun` for the partial byte.
- A completion and acceptance in the same cycle load the new byte; `rx_valid` stays 1.

## Test plan
- **Basic frame.** Tick every 4 clk; send 0xA5 8N1 with `rx_ready`=1.
  - `rx_valid` is high for 1 clk with `rx_data`=0xA5, `rx_ferr`=0.
  - It asserts 1 clk after tick 153 from the detect tick.
- **False start.** `rxd` low for 5 ticks, then high.
  - No `rx_valid`; `busy` falls 1 clk after the `tcnt`=9 tick; state is IDLE.
- **Framing error.** Send 0x3C with stop bit 0.
  - `rx_data`=0x3C, `rx_ferr`=1, `rx_valid`=1.
  - The next frame, 0x00 with a valid stop, is received normally.
- **Overrun.** Back-to-back 0x11 and 0x22 with `rx_ready`=0.
  - `rx_data` holds 0x11 and `overrun` pulses for exactly 1 clk at the second completion.
  - Raising `rx_ready` consumes 0x11, then `rx_valid`=0.
- **Noise rejection.** Send 0xFF with a 1-tick low glitch on `rxd` at sample tick 8 of bit 3.
  - `rx_data`=0xFF, `rx_ferr`=0.
- **Abort.** Drop `enable` during bit 4 of 0x5A, and separately drop `nrst` during bit 2.
  - No `rx_valid`; outputs are at reset values after `nrst`.
  - After re-enable or release, 0x5A is received correctly.
